logic_tile_switch_box: RTL and testbench

LOGIC_TILE_SWITCH_BOX -- requirements
Module: logic_tile_switch_box

---
 rtl/logic_tile_switch_box.sv | 91 +++++++++
 tb/tb_logic_tile_switch_box.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_tile_switch_box.sv
// Logic tile (5-input LUT with optional output register) plus a 4x4 OR-crossbar
// switch box, both configured through a shared 32-bit word-addressed port.
module logic_tile_switch_box (
    input  logic        clock,
    input  logic        reset,
    input  logic        in1,
    input  logic        in2,
    input  logic        in3,
    input  logic        in4,
    input  logic        in5,
    output logic        out_lt,
    input  logic [3:0]  in_sb,
    output logic [3:0]  out_sb,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic [31:0] cfg_rdata
);

    localparam int unsigned LUT_W    = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned SB_IN    = 4;
    localparam int unsigned SB_OUT   = 4;
    localparam int unsigned SB_CFG_W = SB_IN * SB_OUT;
    localparam int unsigned DATA_W   = 32;

    localparam logic [1:0] ADDR_LUT  = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_SB   = 2'd2;

    logic [LUT_W-1:0]    lut_mem;
    logic                mode;
    logic [SB_CFG_W-1:0] sb_cfg;
    logic                lut_q;
    logic [IDX_W-1:0]    lut_idx;
    logic                lut_val;

    // LUT lookup: in1 is the index LSB, in5 the MSB
    always_comb begin
        lut_idx = {in5, in4, in3, in2, in1};
        lut_val = lut_mem[lut_idx];
    end

    // Configuration registers and LUT output flop; reset wins over a write
    always_ff @(posedge clock) begin
        if (reset) begin
            lut_mem <= '0;
            mode    <= 1'b0;
            sb_cfg  <= '0;
            lut_q   <= 1'b0;
        end else begin
            // Captures the LUT value from the configuration in force before any same-edge write
            lut_q <= lut_val;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_LUT:  lut_mem <= cfg_data;
                    ADDR_MODE: mode    <= cfg_data[0];
                    ADDR_SB:   sb_cfg  <= cfg_data[SB_CFG_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    // Tile output: bypass (combinational) or registered LUT value
    always_comb begin
        out_lt = mode ? lut_q : lut_val;
    end

    // Crossbar: output i ORs every input j whose enable bit sb_cfg[4*i+j] is set
    always_comb begin
        out_sb = '0;
        for (int unsigned i = 0; i < SB_OUT; i++) begin
            for (int unsigned j = 0; j < SB_IN; j++) begin
                out_sb[i] = out_sb[i] | (in_sb[j] & sb_cfg[SB_IN*i + j]);
            end
        end
    end

    // Zero-extended readback; the reserved word reads as zero
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_LUT:  cfg_rdata = lut_mem;
            ADDR_MODE: cfg_rdata = DATA_W'(mode);
            ADDR_SB:   cfg_rdata = DATA_W'(sb_cfg);
            default:   cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_logic_tile_switch_box.sv
// Bench for logic_tile_switch_box: directed vector table, hand-timed sequences
// for the bypass/registered LUT paths, then random traffic against a word-level model.
module tb_logic_tile_switch_box;

    logic        clock = 1'b0;
    logic        reset;
    logic        in1, in2, in3, in4, in5;
    logic        out_lt;
    logic [3:0]  in_sb;
    logic [3:0]  out_sb;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] cfg_rdata;

    logic_tile_switch_box dut (
        .clock     (clock),
        .reset     (reset),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .in5       (in5),
        .out_lt    (out_lt),
        .in_sb     (in_sb),
        .out_sb    (out_sb),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // Word-level model: one entry per address, stored already masked to its width
    logic [31:0] m_cfg [4];
    logic        m_lutq;
    logic [31:0] m_mask [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_0000};
    logic [4:0]  cur_ins;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [4:0]  ins;
        logic [3:0]  sb;
        logic        chk;
        logic        exp_lt;
        logic [3:0]  exp_sb;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic we, logic [1:0] addr, logic [31:0] data,
                                logic [4:0] ins, logic [3:0] sb, logic chk,
                                logic exp_lt, logic [3:0] exp_sb, logic [31:0] exp_rd);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.data = data; v.ins = ins; v.sb = sb;
        v.chk = chk; v.exp_lt = exp_lt; v.exp_sb = exp_sb; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic m_lut_bit(logic [31:0] lut, logic [4:0] idx);
        return logic'((lut >> idx) & 32'd1);
    endfunction

    function automatic logic [3:0] m_xbar(logic [31:0] cfg, logic [3:0] sb);
        logic [3:0] o = 4'b0000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (((cfg >> (4*i + j)) & 32'd1) != 0 && sb[j])
                    o[i] = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] addr,
                         input logic [31:0] data, input logic [4:0] ins, input logic [3:0] sb);
        reset = rst; cfg_we = we; cfg_addr = addr; cfg_data = data;
        {in5, in4, in3, in2, in1} = ins;
        cur_ins = ins;
        in_sb = sb;
    endtask

    // Rising edge: advance the model from the values being driven, then move off the edge
    task automatic edge_and_model();
        logic lv;
        @(posedge clock);
        lv = m_lut_bit(m_cfg[0], cur_ins);
        if (reset) begin
            for (int k = 0; k < 4; k++) m_cfg[k] = '0;
            m_lutq = 1'b0;
        end else begin
            m_lutq = lv;
            if (cfg_we) m_cfg[cfg_addr] = cfg_data & m_mask[cfg_addr];
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic exp_lt;
        exp_lt = m_cfg[1][0] ? m_lutq : m_lut_bit(m_cfg[0], cur_ins);
        check({tag, "_out_lt"}, 32'(out_lt), 32'(exp_lt));
        check({tag, "_out_sb"}, 32'(out_sb), 32'(m_xbar(m_cfg[2], in_sb)));
        check({tag, "_rdata"}, cfg_rdata, m_cfg[cfg_addr]);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) m_cfg[k] = '0;
        m_lutq = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 32'd0, 5'd0, 4'd0);

        //        rst we addr data           ins        sb       chk lt  sb       rdata
        tbl.push_back(mk(1, 0, 0, 32'h0,         5'b00000, 4'b0000, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h8000_0001, 5'b00000, 4'b0000, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 1, 32'h0,         5'b00000, 4'b0000, 1, 1, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         5'b01100, 4'b0000, 1, 0, 4'b0000, 32'h8000_0001));
        tbl.push_back(mk(0, 0, 0, 32'h0,         5'b11111, 4'b0000, 1, 1, 4'b0000, 32'h8000_0001));
        tbl.push_back(mk(0, 1, 1, 32'h1,         5'b01100, 4'b0000, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b01100, 4'b0000, 1, 0, 4'b0000, 32'h1));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b11111, 4'b0000, 1, 0, 4'b0000, 32'h1));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b01100, 4'b0000, 1, 1, 4'b0000, 32'h1));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b01100, 4'b0000, 1, 0, 4'b0000, 32'h1));
        tbl.push_back(mk(0, 1, 2, 32'h8421,      5'b01100, 4'b0101, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b01100, 4'b0101, 1, 0, 4'b0101, 32'h8421));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b01100, 4'b0011, 1, 0, 4'b0011, 32'h8421));
        tbl.push_back(mk(0, 1, 2, 32'h1248,      5'b01100, 4'b0101, 1, 0, 4'b0101, 32'h8421));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b01100, 4'b0101, 1, 0, 4'b1010, 32'h1248));
        tbl.push_back(mk(0, 1, 2, 32'h1111,      5'b01100, 4'b0001, 1, 0, 4'b1000, 32'h1248));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b01100, 4'b0001, 1, 0, 4'b1111, 32'h1111));
        tbl.push_back(mk(0, 1, 2, 32'h000F,      5'b01100, 4'b0100, 1, 0, 4'b0000, 32'h1111));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b01100, 4'b0100, 1, 0, 4'b0001, 32'h000F));
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFE, 5'b01100, 4'b0100, 1, 0, 4'b0001, 32'h1));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b00000, 4'b0100, 1, 1, 4'b0001, 32'h0));
        tbl.push_back(mk(0, 1, 3, 32'hFFFF_FFFF, 5'b00000, 4'b0100, 1, 1, 4'b0001, 32'h0));
        tbl.push_back(mk(0, 0, 3, 32'h0,         5'b00000, 4'b0100, 1, 1, 4'b0001, 32'h0));
        tbl.push_back(mk(0, 1, 2, 32'hABCD_1234, 5'b00000, 4'b0000, 1, 1, 4'b0000, 32'h000F));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b00000, 4'b0000, 1, 1, 4'b0000, 32'h1234));
        tbl.push_back(mk(1, 1, 0, 32'hFFFF_FFFF, 5'b00000, 4'b0100, 1, 1, 4'b0001, 32'h8000_0001));
        tbl.push_back(mk(0, 0, 0, 32'h0,         5'b00000, 4'b0100, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h0,         5'b11111, 4'b1111, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 2, 32'h0,         5'b11111, 4'b1111, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 3, 32'h0,         5'b11111, 4'b1111, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3, 32'h1234_5678, 5'b11111, 4'b1111, 1, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 0, 3, 32'h0,         5'b11111, 4'b1111, 1, 0, 4'b0000, 32'h0));

        // Directed table: inputs are applied after an edge, outputs checked before the next
        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].we, tbl[n].addr, tbl[n].data, tbl[n].ins, tbl[n].sb);
            @(negedge clock);
            if (tbl[n].chk) begin
                check($sformatf("tbl%0d_out_lt", n), 32'(out_lt), 32'(tbl[n].exp_lt));
                check($sformatf("tbl%0d_out_sb", n), 32'(out_sb), 32'(tbl[n].exp_sb));
                check($sformatf("tbl%0d_rdata", n), cfg_rdata, tbl[n].exp_rd);
            end
            edge_and_model();
        end

        // Bypass mode: output follows the LUT inputs with no clock edge in between
        drive(1'b0, 1'b1, 2'd0, 32'h8000_0001, 5'b01100, 4'b0000);
        edge_and_model();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 5'b00000, 4'b0000);
        #1 check("comb_idx0", 32'(out_lt), 32'd1);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 5'b01100, 4'b0000);
        #1 check("comb_idx12", 32'(out_lt), 32'd0);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 5'b11111, 4'b0000);
        #1 check("comb_idx31", 32'(out_lt), 32'd1);

        // Registered mode: a mid-cycle input change only shows after the next edge
        @(negedge clock);
        drive(1'b0, 1'b1, 2'd1, 32'h1, 5'b01100, 4'b0000);
        edge_and_model();
        drive(1'b0, 1'b0, 2'd1, 32'h0, 5'b01100, 4'b0000);
        edge_and_model();
        #1 check("reg_hold_idx12", 32'(out_lt), 32'd0);
        drive(1'b0, 1'b0, 2'd1, 32'h0, 5'b11111, 4'b0000);
        #2 check("reg_midcycle_hold", 32'(out_lt), 32'd0);
        @(negedge clock);
        #2 check("reg_before_edge", 32'(out_lt), 32'd0);
        edge_and_model();
        check("reg_after_edge", 32'(out_lt), 32'd1);
        drive(1'b0, 1'b0, 2'd1, 32'h0, 5'b01100, 4'b0000);
        #2 check("reg_back_hold", 32'(out_lt), 32'd1);
        edge_and_model();
        check("reg_back_edge", 32'(out_lt), 32'd0);

        // Random traffic against the model, starting from a fresh reset
        drive(1'b1, 1'b0, 2'd0, 32'h0, 5'd0, 4'd0);
        edge_and_model();
        for (int n = 0; n < 600; n++) begin
            logic r;
            r = ($urandom_range(0, 39) == 0);
            drive(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                  5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            #2 check_model($sformatf("rnd%0d", n));
            edge_and_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
